// File: rtl/rst_seq_clken_gen_pkg.sv
// +--- rst_seq_pkg : shared FSM state encoding and width helpers for rst_seq_clken_gen ---+
// +--- rev 1.0 --------------------------------------------------------------------------+
`default_nettype none

package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2,
    ST_TMO     = 2'd3
  } seq_state_t;

  // $clog2 collapses to 0 for tiny ranges; every counter keeps at least one bit.
  function automatic int unsigned clamp_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return clamp_w((a > b) ? a : b);
  endfunction

  function automatic int unsigned wd_width(input int unsigned timeout);
    return clamp_w(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_seq_clken_gen_clken_div.sv
// +--- clken_div : per-channel divide-ratio latch and wrapping clock-enable counter ---+
// +--- rev 1.0 -----------------------------------------------------------------------+
`default_nettype none

module clken_div
  import rst_seq_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clken_o
);

  logic [DIV_W-1:0] r_term;
  logic [DIV_W-1:0] r_cnt;

  // While held, the ratio tracks div_i, so the value captured is the one present
  // on the release edge; a ratio of 0 clamps to 1 (terminal count 0).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_term <= '0;
      r_cnt  <= '0;
    end else if (!run_i) begin
      r_cnt  <= '0;
      r_term <= (div_i == '0) ? '0 : div_i - 1'b1;
    end else begin
      r_cnt  <= (r_cnt == r_term) ? '0 : r_cnt + 1'b1;
    end
  end

  assign clken_o = run_i && (r_cnt == r_term);

endmodule

`default_nettype wire

// File: rtl/rst_seq_clken_gen.sv
// +--- rst_seq_clken_gen : staggered reset release, kickable watchdog, per-channel clock-enables ---+
// +--- rev 1.0 ------------------------------------------------------------------------------------+
`default_nettype none

module rst_seq_clken_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DIV_W        = 16,
  parameter int RST_CYCLES   = 35,
  parameter int RST_STAGGER  = 8,
  parameter int TIMEOUT      = 1000000,
  parameter int AUTO_RESTART = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    kick_i,
  output logic [NUM_CH-1:0]       rst_o,
  output logic [NUM_CH-1:0]       rst_n_o,
  output logic [NUM_CH-1:0]       clken_o,
  output logic                    all_rdy_o,
  output logic                    timeout_o
);

  localparam int CNT_W = cnt_width(RST_CYCLES, RST_STAGGER);
  localparam int WD_W  = wd_width(TIMEOUT);
  localparam int CH_W  = clamp_w(NUM_CH);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(RST_STAGGER - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam bit               WD_EN      = (TIMEOUT != 0);
  localparam bit               RESTART_EN = (AUTO_RESTART != 0);

  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_next_ch;
  logic [WD_W-1:0]   r_wd;
  logic [NUM_CH-1:0] r_rst;
  logic [NUM_CH-1:0] r_rst_n;
  logic              r_all_rdy;
  logic              r_timeout;

  // rst and rst_n are written side by side so they can never skew.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_HOLD;
      r_cnt     <= '0;
      r_next_ch <= '0;
      r_wd      <= '0;
      r_rst     <= '1;
      r_rst_n   <= '0;
      r_all_rdy <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt      <= '0;
            r_rst[0]   <= 1'b0;
            r_rst_n[0] <= 1'b1;
            if (NUM_CH == 1) begin
              r_state   <= ST_RUN;
              r_all_rdy <= 1'b1;
              r_wd      <= '0;
            end else begin
              r_state   <= ST_STAGGER;
              r_next_ch <= CH_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_STAGGER: begin
          if (r_cnt == STAG_LAST) begin
            r_cnt              <= '0;
            r_rst[r_next_ch]   <= 1'b0;
            r_rst_n[r_next_ch] <= 1'b1;
            if (r_next_ch == LAST_CH) begin
              r_state   <= ST_RUN;
              r_all_rdy <= 1'b1;
              r_wd      <= '0;
            end else begin
              r_next_ch <= r_next_ch + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          // A kick on the terminal-count cycle takes priority over expiry.
          if (kick_i) begin
            r_wd <= '0;
          end else if (WD_EN && (r_wd == WD_LAST)) begin
            r_state   <= ST_TMO;
            r_timeout <= 1'b1;
            r_rst     <= '1;
            r_rst_n   <= '0;
            r_all_rdy <= 1'b0;
            r_wd      <= '0;
          end else if (WD_EN) begin
            r_wd <= r_wd + 1'b1;
          end
        end

        ST_TMO: begin
          if (RESTART_EN) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_next_ch <= '0;
            r_wd      <= '0;
          end
        end

        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

  assign rst_o     = r_rst;
  assign rst_n_o   = r_rst_n;
  assign all_rdy_o = r_all_rdy;
  assign timeout_o = r_timeout;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clken_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .run_i  (r_rst_n[k]),
      .div_i  (div_i[k*DIV_W +: DIV_W]),
      .clken_o(clken_o[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_clken_gen.sv
// +--- tb_rst_seq_clken_gen : directed self-checking bench, auto-restart and latched-timeout instances ---+
// +--- rev 1.0 ----------------------------------------------------------------------------------------+
`default_nettype none

module tb_rst_seq_clken_gen;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    kick;
  logic [NUM_CH*DIV_W-1:0] div;

  logic [NUM_CH-1:0] a_rst, a_rstn, a_ck;
  logic [NUM_CH-1:0] b_rst, b_rstn, b_ck;
  logic              a_rdy, a_tmo, b_rdy, b_tmo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rst_seq_clken_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_CYCLES(35), .RST_STAGGER(8),
    .TIMEOUT(100), .AUTO_RESTART(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .div_i(div), .kick_i(kick),
    .rst_o(a_rst), .rst_n_o(a_rstn), .clken_o(a_ck),
    .all_rdy_o(a_rdy), .timeout_o(a_tmo)
  );

  rst_seq_clken_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_CYCLES(35), .RST_STAGGER(8),
    .TIMEOUT(100), .AUTO_RESTART(0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .div_i(div), .kick_i(kick),
    .rst_o(b_rst), .rst_n_o(b_rstn), .clken_o(b_ck),
    .all_rdy_o(b_rdy), .timeout_o(b_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after edge e of a release sequence (e<=0: still held).
  // Releases at E35/E43/E51; div {0,4,1} gives ch0 and ch2 constant, ch1 every 4th from E46.
  function automatic logic [2:0] m_rst(input int e);
    return {e < 51, e < 43, e < 35};
  endfunction

  function automatic logic [2:0] m_ck(input int e);
    return {e >= 51, (e >= 46) && (((e - 46) % 4) == 0), e >= 35};
  endfunction

  task automatic check_dut(input string who, input int e, input logic tmo,
                           input logic [2:0] r, input logic [2:0] rn, input logic [2:0] ck,
                           input logic rdy, input logic to);
    chk($sformatf("%s_rst_e%0d", who, e), {29'd0, r}, {29'd0, m_rst(e)});
    chk($sformatf("%s_rstn_e%0d", who, e), {29'd0, rn}, {29'd0, ~m_rst(e)});
    chk($sformatf("%s_clken_e%0d", who, e), {29'd0, ck}, {29'd0, m_ck(e)});
    chk($sformatf("%s_rdy_e%0d", who, e), {31'd0, rdy}, {31'd0, e >= 51});
    chk($sformatf("%s_tmo_e%0d", who, e), {31'd0, to}, {31'd0, tmo});
  endtask

  initial begin
    rst  = 1'b1;
    kick = 1'b0;
    div  = {16'd0, 16'd4, 16'd1};

    tick(); tick(); tick();
    check_dut("A_reset", 0, 1'b0, a_rst, a_rstn, a_ck, a_rdy, a_tmo);
    check_dut("B_reset", 0, 1'b0, b_rst, b_rstn, b_ck, b_rdy, b_tmo);

    // Release, staggered bring-up, then kicks every 50 clocks from the terminal-count edge E151.
    rst = 1'b0;
    for (int e = 1; e <= 1250; e++) begin
      tick();
      check_dut("A", e, 1'b0, a_rst, a_rstn, a_ck, a_rdy, a_tmo);
      check_dut("B", e, 1'b0, b_rst, b_rstn, b_ck, b_rdy, b_tmo);
      kick = ((e + 1) >= 151) && ((e + 1) <= 1151) && (((e + 1 - 151) % 50) == 0);
      if (e == 60)   div = {16'd3, 16'd7, 16'd2};
      if (e == 1200) div = {16'd0, 16'd4, 16'd1};
    end

    // Last kick at E1151, so expiry lands on E1251.
    tick();
    check_dut("A_expire", 0, 1'b1, a_rst, a_rstn, a_ck, a_rdy, a_tmo);
    check_dut("B_expire", 0, 1'b1, b_rst, b_rstn, b_ck, b_rdy, b_tmo);

    // A enters HOLD on E1252 and re-sequences from there; B stays in TMO.
    for (int e = 1252; e <= 1310; e++) begin
      tick();
      check_dut("A_reseq", e - 1252, 1'b1, a_rst, a_rstn, a_ck, a_rdy, a_tmo);
      check_dut("B_tmo", 0, 1'b1, b_rst, b_rstn, b_ck, b_rdy, b_tmo);
    end
    for (int e = 1311; e <= 1751; e++) begin
      tick();
      check_dut("B_tmo", 0, 1'b1, b_rst, b_rstn, b_ck, b_rdy, b_tmo);
      chk($sformatf("A_tmo_sticky_e%0d", e), {31'd0, a_tmo}, 32'd1);
    end

    // Mid-cycle reset pulse must clear everything without a clock edge.
    rst = 1'b1;
    #1;
    check_dut("A_async", 0, 1'b0, a_rst, a_rstn, a_ck, a_rdy, a_tmo);
    check_dut("B_async", 0, 1'b0, b_rst, b_rstn, b_ck, b_rdy, b_tmo);
    tick(); tick(); tick();
    check_dut("B_rst_held", 0, 1'b0, b_rst, b_rstn, b_ck, b_rdy, b_tmo);

    rst = 1'b0;
    for (int e = 1; e <= 42; e++) begin
      tick();
      check_dut("A_pre", e, 1'b0, a_rst, a_rstn, a_ck, a_rdy, a_tmo);
    end

    // Abort mid-stagger (ch0 already out of reset and enabled).
    rst = 1'b1;
    #1;
    check_dut("A_abort", 0, 1'b0, a_rst, a_rstn, a_ck, a_rdy, a_tmo);
    check_dut("B_abort", 0, 1'b0, b_rst, b_rstn, b_ck, b_rdy, b_tmo);
    tick(); tick();

    rst = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      check_dut("A_restart", e, 1'b0, a_rst, a_rstn, a_ck, a_rdy, a_tmo);
      check_dut("B_restart", e, 1'b0, b_rst, b_rstn, b_ck, b_rdy, b_tmo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
